// File: rtl/compdiv_serial_pkg.sv
// compdiv_serial shared types and width helpers
// FSM encoding and derived quotient / iteration widths
package compdiv_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_DIV,
    ST_SIGN,
    ST_DONE
  } state_e;

  function automatic int qw(input int n, input int f);
    return n + 1 + f;
  endfunction

  function automatic int iters(input int n, input int f);
    return 2 * n + f;
  endfunction

endpackage

// File: rtl/compdiv_serial_udiv.sv
// serial_udiv: restoring unsigned divider, one quotient bit per cycle
// Dividend shifts out MSB first while quotient bits shift in from the LSB
module serial_udiv #(
  parameter int DW = 24,
  parameter int VW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic [DW-1:0] quot,
  output logic [VW-1:0] rem
);

  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] dq_q, dq_d;
  logic [VW-1:0] rm_q, rm_d;
  logic [VW-1:0] dv_q, dv_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW:0]   trial;
  logic          ge;

  assign busy = (cnt_q != '0);
  assign quot = dq_q;
  assign rem  = rm_q;

  // Trial subtract of the shifted remainder, load on start
  always_comb begin
    trial = {rm_q, dq_q[DW-1]};
    ge    = (trial >= {1'b0, dv_q});
    dq_d  = dq_q;
    rm_d  = rm_q;
    dv_d  = dv_q;
    cnt_d = cnt_q;
    if (start) begin
      dq_d  = dividend;
      rm_d  = '0;
      dv_d  = divisor;
      cnt_d = CW'(DW);
    end else if (busy) begin
      dq_d  = {dq_q[DW-2:0], ge};
      rm_d  = ge ? VW'(trial - {1'b0, dv_q})
                 : VW'(trial);
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Divider state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dq_q  <= '0;
      rm_q  <= '0;
      dv_q  <= '0;
      cnt_q <= '0;
    end else begin
      dq_q  <= dq_d;
      rm_q  <= rm_d;
      dv_q  <= dv_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/compdiv_serial.sv
// compdiv_serial: sequential complex divider q = a*conj(b)/|b|^2
// Sign-magnitude prep, two serial dividers sharing |b|^2
module compdiv_serial
  import compdiv_serial_pkg::*;
#(
  parameter int N = 8,
  parameter int F = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] a_r,
  input  logic signed [N-1:0] a_i,
  input  logic signed [N-1:0] b_r,
  input  logic signed [N-1:0] b_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N+F:0] q_r,
  output logic signed [N+F:0] q_i,
  output logic                dbz
);

  localparam int W    = qw(N, F);
  localparam int ITER = iters(N, F);
  localparam int PW   = 2 * N + 1;
  localparam int DW   = ITER;
  localparam int VW   = 2 * N;
  localparam int CW   = $clog2(ITER + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic signed [N-1:0] ar_q, ai_q;
  logic signed [N-1:0] br_q, bi_q;
  logic                sr_q, si_q;
  logic                zero_q;
  logic signed [W-1:0] qr_q, qi_q;
  logic                dbz_q;

  logic signed [PW-1:0] num_r, num_i;
  logic signed [VW-1:0] sq_r, sq_i;
  logic [VW-1:0]        den;
  logic [PW-1:0]        mag_r, mag_i;
  logic [DW-1:0]        dvd_r, dvd_i;
  logic                 start;

  logic [DW-1:0]       quo_r, quo_i;
  logic [VW-1:0]       rem_r, rem_i;
  logic                busy_r, busy_i;
  logic signed [W-1:0] qm_r, qm_i;
  logic                unused;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign q_r       = qr_q;
  assign q_i       = qi_q;
  assign dbz       = dbz_q;

  // Numerator, denominator and scaled dividend magnitudes
  always_comb begin
    num_r = PW'(ar_q) * PW'(br_q)
          + PW'(ai_q) * PW'(bi_q);
    num_i = PW'(ai_q) * PW'(br_q)
          - PW'(ar_q) * PW'(bi_q);
    sq_r  = VW'(br_q) * VW'(br_q);
    sq_i  = VW'(bi_q) * VW'(bi_q);
    den   = $unsigned(sq_r) + $unsigned(sq_i);
    mag_r = num_r[PW-1] ? $unsigned(-num_r)
                        : $unsigned(num_r);
    mag_i = num_i[PW-1] ? $unsigned(-num_i)
                        : $unsigned(num_i);
    dvd_r = {mag_r[PW-2:0], {F{1'b0}}};
    dvd_i = {mag_i[PW-2:0], {F{1'b0}}};
  end

  assign start = (state_q == ST_PREP)
               && (den != '0);

  serial_udiv #(.DW(DW), .VW(VW)) u_div_r (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dvd_r),
    .divisor  (den),
    .busy     (busy_r),
    .quot     (quo_r),
    .rem      (rem_r)
  );

  serial_udiv #(.DW(DW), .VW(VW)) u_div_i (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dvd_i),
    .divisor  (den),
    .busy     (busy_i),
    .quot     (quo_i),
    .rem      (rem_i)
  );

  assign qm_r = $signed(quo_r[W-1:0]);
  assign qm_i = $signed(quo_i[W-1:0]);

  assign unused = ^{rem_r, rem_i, busy_r, busy_i,
                    quo_r[DW-1:W], quo_i[DW-1:W]};

  // Next-state and iteration counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_PREP;
      ST_PREP: begin
        state_d = ST_DIV;
        cnt_d   = CW'(ITER - 1);
      end
      ST_DIV: begin
        if (cnt_q == '0) state_d = ST_SIGN;
        else cnt_d = cnt_q - CW'(1);
      end
      ST_SIGN: state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand capture and sign/zero bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_q   <= '0;
      ai_q   <= '0;
      br_q   <= '0;
      bi_q   <= '0;
      sr_q   <= 1'b0;
      si_q   <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && in_valid) begin
        ar_q <= a_r;
        ai_q <= a_i;
        br_q <= b_r;
        bi_q <= b_i;
      end
      if (state_q == ST_PREP) begin
        sr_q   <= num_r[PW-1];
        si_q   <= num_i[PW-1];
        zero_q <= (den == '0);
      end
    end
  end

  // Signed result registers, written once in SIGN
  always_ff @(posedge clk) begin
    if (rst) begin
      qr_q  <= '0;
      qi_q  <= '0;
      dbz_q <= 1'b0;
    end else if (state_q == ST_SIGN) begin
      if (zero_q) begin
        qr_q  <= '0;
        qi_q  <= '0;
        dbz_q <= 1'b1;
      end else begin
        qr_q  <= sr_q ? -qm_r : qm_r;
        qi_q  <= si_q ? -qm_i : qm_i;
        dbz_q <= 1'b0;
      end
    end
  end

endmodule
